// File: rtl/pipeline_controller.sv
// pipeline_controller: IF/ID/EX stage sequencing, UART write arbitration and perf counters
module pipeline_controller #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int UART_GUARD = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       srcreg1_num_ID,
  input  logic [4:0]       srcreg2_num_ID,
  input  logic             src1_used_ID,
  input  logic             src2_used_ID,
  input  logic [4:0]       dstreg_num_EX,
  input  logic             reg_we_EX,
  input  logic             is_load_EX,
  input  logic             is_halt_EX,
  input  logic             br_taken_EX,
  input  logic             uart_req_EX,
  input  logic             uart_busy,
  output logic             pc_en,
  output logic             pc_sel_npc,
  output logic             id_en,
  output logic             id_flush,
  output logic             ex_en,
  output logic             ex_flush,
  output logic             uart_we_o,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic [1:0] {RUN, LOAD_STALL, UART_WAIT, HALT} state_t;
  state_t state;
  logic [2:0] guard_cnt, bub_cnt;
  logic hazard, ubusy, stall_ev, flush_ev;
  // Mealy stage control: priority halt > UART > branch > load-use while running
  always_comb begin
    hazard = is_load_EX & reg_we_EX & (dstreg_num_EX != 5'd0) &
             ((src1_used_ID & (srcreg1_num_ID == dstreg_num_EX)) |
              (src2_used_ID & (srcreg2_num_ID == dstreg_num_EX)));
    ubusy = uart_busy | (guard_cnt != 3'd0);
    pc_en = 1'b1;
    id_en = 1'b1;
    ex_en = 1'b1;
    id_flush = 1'b0;
    ex_flush = 1'b0;
    pc_sel_npc = 1'b0;
    uart_we_o = 1'b0;
    halted = 1'b0;
    stall_ev = 1'b0;
    flush_ev = 1'b0;
    if (rst) begin
      {pc_en, id_en, ex_en} = 3'b000;
      {id_flush, ex_flush} = 2'b11;
    end else begin
      case (state)
        RUN: begin
          if (is_halt_EX) begin
            {pc_en, id_en, ex_en} = 3'b000;
            ex_flush = 1'b1;
          end else if (uart_req_EX) begin
            {pc_en, id_en, ex_en} = ubusy ? 3'b000 : 3'b111;
            uart_we_o = ~ubusy;
            stall_ev = ubusy;
          end else if (br_taken_EX) begin
            pc_sel_npc = 1'b1;
            {id_flush, ex_flush} = 2'b11;
            flush_ev = 1'b1;
          end else if (hazard) begin
            {pc_en, id_en} = 2'b00;
            ex_flush = 1'b1;
            stall_ev = 1'b1;
          end
        end
        LOAD_STALL: begin
          {pc_en, id_en} = 2'b00;
          ex_flush = 1'b1;
          stall_ev = 1'b1;
        end
        UART_WAIT: begin
          {pc_en, id_en, ex_en} = ubusy ? 3'b000 : 3'b111;
          uart_we_o = ~ubusy;
          stall_ev = ubusy;
        end
        HALT: begin
          {pc_en, id_en, ex_en} = 3'b000;
          halted = 1'b1;
        end
        default: ;
      endcase
    end
  end
  // State, bubble/guard counters and saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      guard_cnt <= 3'd0;
      bub_cnt <= 3'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      guard_cnt <= uart_we_o ? 3'(UART_GUARD) : guard_cnt - 3'(guard_cnt != 3'd0);
      stall_count <= stall_count + CNT_W'(stall_ev & ~&stall_count);
      flush_count <= flush_count + CNT_W'(flush_ev & ~&flush_count);
      case (state)
        RUN: begin
          if (is_halt_EX) state <= HALT;
          else if (uart_req_EX & ubusy) state <= UART_WAIT;
          else if (!uart_req_EX & !br_taken_EX & hazard & (LOAD_USE_BUBBLES > 1)) begin
            state <= LOAD_STALL;
            bub_cnt <= 3'(LOAD_USE_BUBBLES - 1);
          end
        end
        LOAD_STALL: begin
          bub_cnt <= bub_cnt - 3'd1;
          if (bub_cnt <= 3'd1) state <= RUN;
        end
        UART_WAIT: if (!ubusy) state <= RUN;
        HALT: state <= HALT;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed scoreboard bench for pipeline_controller
module tb_pipeline_controller;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] srcreg1_num_ID, srcreg2_num_ID, dstreg_num_EX;
  logic src1_used_ID, src2_used_ID, reg_we_EX, is_load_EX, is_halt_EX, br_taken_EX, uart_req_EX, uart_busy;
  logic pc_en, pc_sel_npc, id_en, id_flush, ex_en, ex_flush, uart_we_o, halted;
  logic pc_en2, pc_sel_npc2, id_en2, id_flush2, ex_en2, ex_flush2, uart_we_o2, halted2;
  logic [15:0] stall_count, flush_count, stall_count2, flush_count2;
  logic [7:0] outs, outs2;
  logic [31:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;

  always #5 clk = ~clk;

  pipeline_controller #(.LOAD_USE_BUBBLES(1), .UART_GUARD(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .srcreg1_num_ID(srcreg1_num_ID), .srcreg2_num_ID(srcreg2_num_ID),
    .src1_used_ID(src1_used_ID), .src2_used_ID(src2_used_ID),
    .dstreg_num_EX(dstreg_num_EX), .reg_we_EX(reg_we_EX), .is_load_EX(is_load_EX),
    .is_halt_EX(is_halt_EX), .br_taken_EX(br_taken_EX), .uart_req_EX(uart_req_EX),
    .uart_busy(uart_busy),
    .pc_en(pc_en), .pc_sel_npc(pc_sel_npc), .id_en(id_en), .id_flush(id_flush),
    .ex_en(ex_en), .ex_flush(ex_flush), .uart_we_o(uart_we_o), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_controller #(.LOAD_USE_BUBBLES(3), .UART_GUARD(2), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst),
    .srcreg1_num_ID(srcreg1_num_ID), .srcreg2_num_ID(srcreg2_num_ID),
    .src1_used_ID(src1_used_ID), .src2_used_ID(src2_used_ID),
    .dstreg_num_EX(dstreg_num_EX), .reg_we_EX(reg_we_EX), .is_load_EX(is_load_EX),
    .is_halt_EX(is_halt_EX), .br_taken_EX(br_taken_EX), .uart_req_EX(uart_req_EX),
    .uart_busy(uart_busy),
    .pc_en(pc_en2), .pc_sel_npc(pc_sel_npc2), .id_en(id_en2), .id_flush(id_flush2),
    .ex_en(ex_en2), .ex_flush(ex_flush2), .uart_we_o(uart_we_o2), .halted(halted2),
    .stall_count(stall_count2), .flush_count(flush_count2)
  );

  assign outs = {pc_en, pc_sel_npc, id_en, id_flush, ex_en, ex_flush, uart_we_o, halted};
  assign outs2 = {pc_en2, pc_sel_npc2, id_en2, id_flush2, ex_en2, ex_flush2, uart_we_o2, halted2};

  always @(posedge clk) if (uart_we_o) we_cnt <= we_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // hz: 0 none, 1 load x5 with ID reading x5 as src2, 2 load x0 with ID reading x0
  task automatic drive(input bit r, input bit halt, input bit ureq, input bit busy, input bit br, input logic [1:0] hz);
    rst = r;
    is_halt_EX = halt;
    uart_req_EX = ureq;
    uart_busy = busy;
    br_taken_EX = br;
    is_load_EX = hz != 2'd0;
    reg_we_EX = hz != 2'd0;
    dstreg_num_EX = (hz == 2'd2) ? 5'd0 : 5'd5;
    srcreg2_num_ID = (hz == 2'd2) ? 5'd0 : 5'd5;
    src2_used_ID = hz != 2'd0;
    srcreg1_num_ID = 5'd5;
    src1_used_ID = 1'b0;
  endtask

  // Drive one cycle's inputs, queue the expected stage controls, compare before the edge
  task automatic cyc(input string tag, input bit r, input bit halt, input bit ureq, input bit busy,
                     input bit br, input logic [1:0] hz, input logic [7:0] exp);
    @(negedge clk);
    drive(r, halt, ureq, busy, br, hz);
    sb.push_back({24'd0, exp});
    #2;
    check(tag, {24'd0, outs}, sb.pop_front());
  endtask

  task automatic cnt(input string tag, input logic [15:0] s, input logic [15:0] f);
    @(posedge clk);
    #1;
    sb.push_back({s, f});
    check(tag, {stall_count, flush_count}, sb.pop_front());
  endtask

  localparam logic [7:0] RST = 8'h14, NORM = 8'hA8, HLT = 8'h04, HOLD = 8'h00,
                         STRB = 8'hAA, BR = 8'hFC, BUB = 8'h0C, HALTED = 8'h01;

  initial begin
    drive(1'b1, 0, 0, 0, 0, 2'd0);
    cyc("rst0", 1, 0, 0, 0, 0, 2'd0, RST);
    cyc("rst1", 1, 0, 0, 0, 0, 2'd0, RST);
    cnt("rst_cnt", 16'd0, 16'd0);
    cyc("idle", 0, 0, 0, 0, 0, 2'd0, NORM);
    cyc("lu_haz", 0, 0, 0, 0, 0, 2'd1, BUB);
    check("lu_haz_b3", {24'd0, outs2}, {24'd0, BUB});
    cyc("lu_next", 0, 0, 0, 0, 0, 2'd0, NORM);
    check("lu_next_b3", {24'd0, outs2}, {24'd0, BUB});
    cyc("lu_next2", 0, 0, 0, 0, 0, 2'd0, NORM);
    check("lu_next2_b3", {24'd0, outs2}, {24'd0, BUB});
    cyc("lu_done", 0, 0, 0, 0, 0, 2'd0, NORM);
    check("lu_done_b3", {24'd0, outs2}, {24'd0, NORM});
    check("lu_cnt_b3", {16'd0, stall_count2}, 32'd3);
    cnt("lu_cnt", 16'd1, 16'd0);
    cyc("lu_x0", 0, 0, 0, 0, 0, 2'd2, NORM);
    cyc("br_haz", 0, 0, 0, 0, 1, 2'd1, BR);
    cnt("br_cnt", 16'd1, 16'd1);
    cyc("u0_fire", 0, 0, 1, 0, 0, 2'd0, STRB);
    cyc("u1_guard2", 0, 0, 1, 0, 0, 2'd0, HOLD);
    cyc("u1_guard1", 0, 0, 1, 0, 0, 2'd0, HOLD);
    cyc("u1_fire", 0, 0, 1, 0, 0, 2'd0, STRB);
    cyc("u_idle", 0, 0, 0, 0, 0, 2'd0, NORM);
    check("u_pulses", we_cnt, 32'd2);
    cnt("u_cnt", 16'd3, 16'd1);
    cyc("u_idle2", 0, 0, 0, 0, 0, 2'd0, NORM);
    for (int i = 0; i < 5; i++) cyc($sformatf("busy_%0d", i), 0, 0, 1, 1, 0, 2'd0, HOLD);
    cyc("busy_fire", 0, 0, 1, 0, 0, 2'd0, STRB);
    cnt("busy_cnt", 16'd8, 16'd1);
    check("busy_pulses", we_cnt, 32'd3);
    cyc("pre_w0", 0, 0, 0, 0, 0, 2'd0, NORM);
    cyc("pre_w1", 0, 0, 0, 0, 0, 2'd0, NORM);
    cyc("wait_enter", 0, 0, 1, 1, 0, 2'd0, HOLD);
    cyc("wait_rst", 1, 0, 1, 1, 0, 2'd0, RST);
    cyc("after_rst", 0, 0, 0, 0, 0, 2'd0, NORM);
    cnt("wait_rst_cnt", 16'd0, 16'd0);
    cyc("after_rst2", 0, 0, 0, 0, 0, 2'd0, NORM);
    check("wait_rst_pulses", we_cnt, 32'd3);
    cyc("pre_halt_haz", 0, 0, 0, 0, 0, 2'd1, BUB);
    cyc("halt_ex", 0, 1, 0, 0, 0, 2'd0, HLT);
    cyc("halted", 0, 0, 0, 0, 0, 2'd0, HALTED);
    cyc("halted_br", 0, 0, 1, 0, 1, 2'd1, HALTED);
    cnt("halt_cnt", 16'd1, 16'd0);
    cyc("halt_rst", 1, 0, 0, 0, 0, 2'd0, RST);
    cyc("halt_exit", 0, 0, 0, 0, 0, 2'd0, NORM);
    cnt("halt_rst_cnt", 16'd0, 16'd0);
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 0, 2'd1);
    repeat (65539) @(posedge clk);
    #1;
    check("sat_stall", {16'd0, stall_count}, 32'd65535);
    check("sat_stall_b3", {16'd0, stall_count2}, 32'd65535);
    cyc("sat_end", 0, 0, 0, 0, 0, 2'd0, NORM);
    cnt("sat_hold", 16'hFFFF, 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
